// File: rtl/seq_detector_param.sv
// Runtime-configurable serial bit-pattern detector with registered match pulse,
// saturating match counter and prefix-progress (FSM-equivalent state) output.
module seq_detector_param #(
   parameter int unsigned          MAX_LEN         = 8,
   parameter int unsigned          CNT_W           = 8,
   parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = 8'b0000_1011,
   parameter int unsigned          DEFAULT_LEN     = 4,
   parameter bit                   DEFAULT_OVERLAP = 1'b1,
   localparam int unsigned         LEN_W           = $clog2(MAX_LEN + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   input  logic               w,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   output logic               z,
   output logic [CNT_W-1:0]   match_count,
   output logic               count_sat,
   output logic [LEN_W-1:0]   prefix_len,
   output logic               cfg_err
);

   logic [MAX_LEN-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               overlap_q, overlap_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               z_q, z_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               sat_q, sat_d;
   logic [LEN_W-1:0]   prefix_q, prefix_d;
   logic               err_q, err_d;

   logic [MAX_LEN-1:0] hist_new;
   logic [LEN_W-1:0]   fill_new;
   logic [MAX_LEN-1:0] mask_len;
   logic [MAX_LEN-1:0] mask_k;
   logic [MAX_LEN-1:0] pat_top;
   logic [LEN_W-1:0]   prefix_new;
   logic               match;
   logic               cfg_legal;

   // Candidate history/fill and match/prefix evaluation for an accepted bit.
   always_comb begin
      hist_new   = {hist_q[MAX_LEN-2:0], w};
      fill_new   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
      mask_len   = ~({MAX_LEN{1'b1}} << len_q);
      match      = (fill_new >= len_q) && (((hist_new ^ pattern_q) & mask_len) == '0);
      prefix_new = '0;
      mask_k     = '0;
      pat_top    = '0;
      // Ascending scan so the largest qualifying prefix wins.
      for (int k = 1; k < MAX_LEN; k++) begin
         mask_k  = ~({MAX_LEN{1'b1}} << k);
         pat_top = pattern_q >> (len_q - LEN_W'(k));
         if ((LEN_W'(k) < len_q) && (LEN_W'(k) <= fill_new) &&
             (((hist_new ^ pat_top) & mask_k) == '0)) begin
            prefix_new = LEN_W'(k);
         end
      end
   end

   assign cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

   always_comb begin
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      z_d       = 1'b0;
      count_d   = count_q;
      sat_d     = sat_q;
      prefix_d  = prefix_q;
      err_d     = 1'b0;
      if (cfg_load) begin
         if (cfg_legal) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
            fill_d    = '0;
            count_d   = '0;
            sat_d     = 1'b0;
            prefix_d  = '0;
         end else begin
            err_d = 1'b1;
         end
      end else if (in_valid) begin
         hist_d   = hist_new;
         fill_d   = fill_new;
         prefix_d = prefix_new;
         if (match) begin
            z_d = 1'b1;
            if (count_q == '1) begin
               sat_d = 1'b1;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
            if (!overlap_q) begin
               fill_d   = '0;
               prefix_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pattern_q <= DEFAULT_PATTERN;
         len_q     <= LEN_W'(DEFAULT_LEN);
         overlap_q <= DEFAULT_OVERLAP;
         hist_q    <= '0;
         fill_q    <= '0;
         z_q       <= 1'b0;
         count_q   <= '0;
         sat_q     <= 1'b0;
         prefix_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         z_q       <= z_d;
         count_q   <= count_d;
         sat_q     <= sat_d;
         prefix_q  <= prefix_d;
         err_q     <= err_d;
      end
   end

   assign z           = z_q;
   assign match_count = count_q;
   assign count_sat   = sat_q;
   assign prefix_len  = prefix_q;
   assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed plus randomized bench for seq_detector_param, checked against a
// queue-based reference model of the detection rules.
module tb_seq_detector_param;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned LEN_W   = 4;

   logic               clock = 1'b0;
   logic               reset, in_valid, w, cfg_load, cfg_overlap;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               z, count_sat, cfg_err;
   logic [CNT_W-1:0]   match_count;
   logic [LEN_W-1:0]   prefix_len;

   int compared = 0;
   int mismatched = 0;

   // Reference model state
   bit           q[$];
   logic [7:0]   m_pat;
   int           m_len;
   bit           m_ov;
   int           m_cnt;
   bit           m_sat;
   bit           exp_z, exp_err;
   int           exp_pref;

   seq_detector_param #(
      .MAX_LEN(MAX_LEN),
      .CNT_W  (CNT_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .w          (w),
      .cfg_load   (cfg_load),
      .cfg_pattern(cfg_pattern),
      .cfg_len    (cfg_len),
      .cfg_overlap(cfg_overlap),
      .z          (z),
      .match_count(match_count),
      .count_sat  (count_sat),
      .prefix_len (prefix_len),
      .cfg_err    (cfg_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      compared++;
      assert (got === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic bool_tail_eq(input int k);
      // True when the newest k received bits equal pattern[len-1 : len-k].
      if (k > q.size()) return 1'b0;
      for (int i = 0; i < k; i++)
         if (q[q.size() - 1 - i] != m_pat[m_len - k + i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int model_prefix();
      for (int k = m_len - 1; k >= 1; k--)
         if (bool_tail_eq(k)) return k;
      return 0;
   endfunction

   task automatic model_reset();
      q.delete();
      m_pat = 8'b0000_1011; m_len = 4; m_ov = 1'b1;
      m_cnt = 0; m_sat = 1'b0; exp_z = 1'b0; exp_err = 1'b0; exp_pref = 0;
   endtask

   task automatic step(input bit rst, input bit ld, input logic [7:0] p, input int l,
                       input bit ov, input bit v, input bit b);
      reset = rst; cfg_load = ld; cfg_pattern = p; cfg_len = LEN_W'(l);
      cfg_overlap = ov; in_valid = v; w = b;
      @(posedge clock);
      #1;
      exp_z = 1'b0; exp_err = 1'b0;
      if (rst) begin
         model_reset();
      end else if (ld) begin
         if (l >= 1 && l <= MAX_LEN) begin
            m_pat = p; m_len = l; m_ov = ov; q.delete();
            m_cnt = 0; m_sat = 1'b0; exp_pref = 0;
         end else begin
            exp_err = 1'b1;
         end
      end else if (v) begin
         q.push_back(b);
         if (q.size() > MAX_LEN) void'(q.pop_front());
         if (bool_tail_eq(m_len)) begin
            exp_z = 1'b1;
            if (m_cnt == (1 << CNT_W) - 1) m_sat = 1'b1;
            else m_cnt++;
            if (!m_ov) q.delete();
         end
         exp_pref = model_prefix();
      end
      check("z", 16'(z), 16'(exp_z));
      check("match_count", 16'(match_count), 16'(m_cnt));
      check("count_sat", 16'(count_sat), 16'(m_sat));
      check("prefix_len", 16'(prefix_len), 16'(exp_pref));
      check("cfg_err", 16'(cfg_err), 16'(exp_err));
   endtask

   task automatic bit_in(input bit b);
      step(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, b);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [7:0] p, input int l, input bit ov);
      step(1'b0, 1'b1, p, l, ov, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [6:0] s7;
      s7 = 7'b1011011;
      model_reset();
      do_reset();
      check("reset_count", 16'(match_count), 16'd0);

      // Default config, overlapping stream 1011011
      for (int i = 6; i >= 0; i--) bit_in(s7[i]);
      check("ov1_count", 16'(match_count), 16'd2);
      check("ov1_prefix", 16'(prefix_len), 16'd1);

      // Non-overlapping
      load(8'b0000_1011, 4, 1'b0);
      for (int i = 6; i >= 0; i--) bit_in(s7[i]);
      check("ov0_count", 16'(match_count), 16'd1);

      // Default config with gaps
      do_reset();
      for (int i = 6; i >= 3; i--) begin
         idle(); idle();
         bit_in(s7[i]);
      end
      idle();
      check("gap_count", 16'(match_count), 16'd1);

      // Saturation with single-bit pattern
      load(8'b0000_0001, 1, 1'b1);
      for (int i = 0; i < 8; i++) bit_in(1'b1);
      check("sat_count", 16'(match_count), 16'd3);
      check("sat_flag", 16'(count_sat), 16'd1);
      load(8'b0000_0001, 1, 1'b1);

      // Illegal loads keep default config; load wins over in_valid
      do_reset();
      load(8'hFF, 0, 1'b0);
      load(8'hFF, 9, 1'b0);
      for (int i = 6; i >= 3; i--) bit_in(s7[i]);
      check("illegal_keep", 16'(match_count), 16'd1);
      bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
      step(1'b0, 1'b1, 8'b0000_0011, 2, 1'b1, 1'b1, 1'b1);
      bit_in(1'b1);
      check("drop_bit_z", 16'(z), 16'd0);

      // Reset mid-stream, also during cfg_load
      bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
      step(1'b1, 1'b1, 8'h03, 2, 1'b0, 1'b1, 1'b1);
      bit_in(1'b1);
      for (int i = 6; i >= 3; i--) bit_in(s7[i]);

      // Randomized phase
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 1) begin
            step(1'b1, 1'($urandom), 8'($urandom), $urandom_range(0, 15), 1'($urandom),
                 1'($urandom), 1'($urandom));
         end else if (r < 4) begin
            step(1'b0, 1'b1, 8'($urandom),
                 ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 5),
                 1'($urandom), 1'($urandom), 1'($urandom));
         end else begin
            step(1'b0, 1'b0, 8'($urandom), $urandom_range(0, 15), 1'($urandom),
                 ($urandom_range(0, 3) != 0), 1'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector. Successor to the team's fixed 8-state sequence-detector FSMs. Pattern, length and overlap mode are runtime-configurable. Adds a registered match pulse, a saturating match counter and a prefix-progress output that plays the role of the old "present state". Sits on a 1-bit serial input stream inside lab/datapath designs.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, match counter width
DEFAULT_PATTERN, 8'b0000_1011, pattern after reset (low DEFAULT_LEN bits used)
DEFAULT_LEN, 4, pattern length after reset (1..MAX_LEN)
DEFAULT_OVERLAP, 1, overlap mode after reset
LEN_W, clog2(MAX_LEN+1), derived localparam, width of length fields

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  w is sampled this cycle
w  in  1  serial data bit
cfg_load  in  1  load new configuration this cycle
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] is the last
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
z  out  1  one-cycle match pulse (registered)
match_count  out  CNT_W  number of matches, saturating
count_sat  out  1  sticky: counter has saturated
prefix_len  out  LEN_W  length of the pattern prefix currently matched
cfg_err  out  1  one-cycle pulse: illegal configuration rejected

Behaviour:
- Reset (synchronous): config set to DEFAULT_*; history and fill set to 0; z, match_count, count_sat, prefix_len and cfg_err all 0.
- History: shift register hist, newest bit at hist[0]. On an accepted bit: hist <= {hist[MAX_LEN-2:0], w}; fill <= min(fill+1, MAX_LEN).
- Match: evaluated on the updated history. Match when fill_new >= len and hist_new[len-1:0] == pattern[len-1:0].
- z: goes high in the cycle after the completing bit is sampled, for exactly one cycle. z = 0 in any cycle that follows a non-accepted cycle.
- Overlap = 1: after a match, history is kept and fill continues.
- Overlap = 0: after a match, fill <= 0, so the next match needs len fresh bits.
- prefix_len (registered, same timing as z):
  - Equals the largest k < len such that k <= fill_new and the last k bits equal pattern[len-1:len-k]; 0 if no such k.
  - After a match with overlap = 0, it is 0.
  - It is the FSM-equivalent state index.
- match_count: increments by 1 on each match. Stops at 2^CNT_W-1. count_sat is set when an increment is attempted at the maximum and stays set until reset or cfg_load.
- in_valid = 0: history, fill, prefix_len and counter hold; z = 0.
- cfg_load = 1, legal (1 <= cfg_len <= MAX_LEN):
  - Latch pattern, len and overlap.
  - Clear fill, z, prefix_len, match_count and count_sat.
  - Changes take effect for the next accepted bit.
- cfg_load = 1, illegal (cfg_len = 0 or > MAX_LEN): configuration and all state unchanged; cfg_err = 1 in the next cycle for one cycle.
- cfg_load and in_valid in the same cycle: cfg_load wins; the bit is dropped with no shift and no match.
- Reset has priority over everything, including mid-stream and during cfg_load.
- Pattern bits above len-1 are ignored.

Test Plan:
- Default config (1011, len 4, overlap 1), stream 1,0,1,1,0,1,1 with in_valid = 1 -> z pulses the cycle after bit 4 and after bit 7; match_count = 2; prefix_len sequence 1,2,3,1,2,3,1.
- Load pattern 1011, len 4, overlap 0; same stream -> single z after bit 4; match_count = 1; prefix_len after bit 4 = 0.
- Default config with in_valid gaps: stream 1,0,1,1 with idle cycles between bits -> z only once, the cycle after the 4th accepted bit; state holds during gaps.
- CNT_W = 2, pattern 1 (len 1), eight 1-bits -> match_count stops at 3; count_sat = 1 after the 4th match; cfg_load clears both.
- cfg_load with cfg_len = 0, then cfg_len = 9 (MAX_LEN = 8) -> cfg_err pulses each time; default 1011 still detected afterwards. cfg_load together with in_valid -> bit dropped.
- Reset asserted after bits 1,0,1 -> all outputs 0; subsequent 1 does not match; a full 1011 is needed.
